// File: rtl/video_ctrl_top_if.sv
// -----------------------------------------------------------------------------
// video_ctrl_top_if.sv
// Interfaces used by video_ctrl_top.
//
//   video_if : raster video bus.
//              CLK   pixel clock
//              HS    horizontal sync, active-low
//              VS    vertical sync, active-low
//              BLANK 1 = display pixel, 0 = porch/sync
//              RGB   24-bit pixel colour
//   hws_if   : hardware-support bus. The master drives addr/wdata/wr/rd and
//              receives rdata/ack from the slave.
//
// Handshake note: hws_if uses a simple strobe/ack scheme; the master raises
// wr or rd for one request and the slave answers with ack. The video
// controller never issues requests, so its side of this bus is held idle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface video_if;
    logic        CLK;
    logic        HS;
    logic        VS;
    logic        BLANK;
    logic [23:0] RGB;

    modport master (output CLK, output HS, output VS, output BLANK, output RGB);
    modport slave  (input  CLK, input  HS, input  VS, input  BLANK, input  RGB);
endinterface

interface hws_if;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        wr;
    logic        rd;
    logic [31:0] rdata;
    logic        ack;

    modport master (output addr, output wdata, output wr, output rd,
                    input  rdata, input  ack);
    modport slave  (input  addr, input  wdata, input  wr, input  rd,
                    output rdata, output ack);
endinterface

// File: rtl/video_ctrl_top.sv
// -----------------------------------------------------------------------------
// video_ctrl_top.sv
// Video controller top level: generates VGA-style raster timing for a small
// frame and paints a 16-pixel grid test pattern. Also drives status LEDs.
//
// Ports:
//   FPGA_CLK1_50  in   sole clock, also the pixel clock
//   sys_rst       in   asynchronous reset, active-high
//   KEY[1:0]      in   push buttons, active-low (KEY[1] = user button)
//   SW[3:0]       in   slide switches
//   LED[7:0]      out  {SW, 0, ~KEY[1], frame toggle, heartbeat}
//   hws_ifm       if   hardware-support bus master, held idle
//   video_ifm     if   video bus master (CLK, HS, VS, BLANK, RGB)
//
// Configuration macro:
//   FAST_BLINK_EN  defined -> heartbeat toggles every 25 clocks;
//                  undefined -> every 25_000_000 clocks (1 Hz at 50 MHz).
//
// Raster layout per axis: front porch, sync, back porch, then active video.
// All video outputs are registered, one clock behind the counter state.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module video_ctrl_top #(
    parameter int HDISP  = 160,
    parameter int VDISP  = 90,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic       FPGA_CLK1_50,
    input  logic       sys_rst,
    input  logic [1:0] KEY,
    input  logic [3:0] SW,
    output logic [7:0] LED,
    hws_if.master      hws_ifm,
    video_if.master    video_ifm
);

    localparam int HTOT  = HFP + HPULSE + HBP + HDISP;
    localparam int VTOT  = VFP + VPULSE + VBP + VDISP;
    localparam int HSTRT = HFP + HPULSE + HBP;   // first active column
    localparam int VSTRT = VFP + VPULSE + VBP;   // first active line
    localparam int HCW   = $clog2(HTOT);
    localparam int VCW   = $clog2(VTOT);

`ifdef FAST_BLINK_EN
    localparam int BLINK_DIV = 25;
`else
    localparam int BLINK_DIV = 25_000_000;
`endif
    localparam int BCW = $clog2(BLINK_DIV);

    logic [HCW-1:0] hc_q, hc_d;
    logic [VCW-1:0] vc_q, vc_d;
    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_led_q, blink_led_d;
    logic           frame_led_q, frame_led_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           blank_q, blank_d;
    logic [23:0]    rgb_q, rgb_d;

    logic           h_wrap;
    logic           v_wrap;
    logic [3:0]     x_lo;
    logic [3:0]     y_lo;

    assign h_wrap = (hc_q == HCW'(HTOT - 1));
    assign v_wrap = (vc_q == VCW'(VTOT - 1));

    // Only the low nibble of x/y matters for the grid; modulo-16 subtraction
    // on the low bits gives the same result as subtracting the full offset.
    assign x_lo = hc_q[3:0] - 4'(HSTRT);
    assign y_lo = vc_q[3:0] - 4'(VSTRT);

    always_comb begin
        hc_d        = hc_q + HCW'(1);
        vc_d        = vc_q;
        frame_led_d = frame_led_q;
        if (h_wrap) begin
            hc_d = '0;
            if (v_wrap) begin
                vc_d        = '0;
                frame_led_d = ~frame_led_q;
            end else begin
                vc_d = vc_q + VCW'(1);
            end
        end
    end

    always_comb begin
        hs_d    = ~((hc_q >= HCW'(HFP)) && (hc_q < HCW'(HFP + HPULSE)));
        vs_d    = ~((vc_q >= VCW'(VFP)) && (vc_q < VCW'(VFP + VPULSE)));
        blank_d = (hc_q >= HCW'(HSTRT)) && (vc_q >= VCW'(VSTRT));
        rgb_d   = 24'h000000;
        if (blank_d && ((x_lo == 4'd0) || (y_lo == 4'd0))) begin
            rgb_d = 24'hFFFFFF;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
        blink_led_d = blink_led_q;
        if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_led_d = ~blink_led_q;
        end
    end

    always_ff @(posedge FPGA_CLK1_50 or posedge sys_rst) begin
        if (sys_rst) begin
            hc_q        <= '0;
            vc_q        <= '0;
            blink_cnt_q <= '0;
            blink_led_q <= 1'b0;
            frame_led_q <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_q     <= 1'b0;
            rgb_q       <= 24'h000000;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_led_q <= blink_led_d;
            frame_led_q <= frame_led_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            rgb_q       <= rgb_d;
        end
    end

    assign video_ifm.CLK   = FPGA_CLK1_50;
    assign video_ifm.HS    = hs_q;
    assign video_ifm.VS    = vs_q;
    assign video_ifm.BLANK = blank_q;
    assign video_ifm.RGB   = rgb_q;

    assign LED = {SW, 1'b0, ~KEY[1], frame_led_q, blink_led_q};

    assign hws_ifm.addr  = '0;
    assign hws_ifm.wdata = '0;
    assign hws_ifm.wr    = 1'b0;
    assign hws_ifm.rd    = 1'b0;

    // KEY[0] is consumed by the board wrapper as reset; bus responses are
    // never expected because no request is ever issued.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, KEY[0], hws_ifm.rdata, hws_ifm.ack};

endmodule

// File: tb/tb_video_ctrl_top.sv
`timescale 1ns/1ps

module tb_video_ctrl_top;

  localparam int FRAME = 38880;  // 288 x 135 clocks

  logic       clk;
  logic       rst;
  logic [1:0] key;
  logic [3:0] sw;
  logic [7:0] led;

  video_if vid ();
  hws_if   hws ();

  int total = 0;
  int bad   = 0;

  logic [34:0] exp_q[$];

  int hs_low   = 0;
  int vs_low   = 0;
  int blank_hi = 0;

  // pixel spot checks: x, y, colour
  int          pix_x[6]   = '{0, 16, 5, 5, 17, -118};
  int          pix_y[6]   = '{0, 5, 16, 5, 17, 5};
  logic [23:0] pix_c[6]   = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                              24'h000000, 24'h000000, 24'h000000};

  video_ctrl_top dut (
    .FPGA_CLK1_50 (clk),
    .sys_rst      (rst),
    .KEY          (key),
    .SW           (sw),
    .LED          (led),
    .hws_ifm      (hws),
    .video_ifm    (vid)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [34:0] got, input logic [34:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Output word at clock n after reset release reflects raster position n-1.
  function automatic logic [34:0] model(input int n, input logic [3:0] s, input logic k1);
    int p, hc, vc, x, y;
    logic hs, vs, bl, l0, l1;
    logic [23:0] rgb;
    p   = (n - 1) % FRAME;
    hc  = p % 288;
    vc  = p / 288;
    hs  = !(hc >= 40 && hc < 88);
    vs  = !(vc >= 13 && vc < 16);
    bl  = (hc >= 128) && (vc >= 45);
    x   = hc - 128;
    y   = vc - 45;
    rgb = (bl && ((x % 16) == 0 || (y % 16) == 0)) ? 24'hFFFFFF : 24'h000000;
    l1  = ((n / FRAME) % 2) == 1;
`ifdef FAST_BLINK_EN
    l0  = ((n / 25) % 2) == 1;
`else
    l0  = 1'b0;
`endif
    return {hs, vs, bl, rgb, s, 1'b0, ~k1, l1, l0};
  endfunction

  // ---------------- driver ----------------
  task automatic run_cycles(input int ncyc, input bit do_count);
    logic [34:0] got;
    logic [34:0] expv;
    int p, hc, vc;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      if ((n % 1000) == 1) check_val("vclk_hi", {34'd0, vid.CLK}, 35'd1);
      if ($urandom_range(0, 63) == 0) begin
        sw        = 4'($urandom_range(0, 15));
        key       = 2'($urandom_range(0, 3));
        hws.rdata = $urandom;
        hws.ack   = 1'($urandom_range(0, 1));
      end
      exp_q.push_back(model(n, sw, key[1]));
      @(negedge clk);
      got  = {vid.HS, vid.VS, vid.BLANK, vid.RGB, led};
      expv = exp_q.pop_front();
      check_val("raster", got, expv);
      if ((n % 1000) == 2) check_val("vclk_lo", {34'd0, vid.CLK}, 35'd0);
      if ((n % 288) == 5)
        check_val("hws_idle", {hws.addr[2:0], hws.wdata, hws.wr, hws.rd}, 35'd0);
      p  = (n - 1) % FRAME;
      hc = p % 288;
      vc = p / 288;
      for (int i = 0; i < 6; i++) begin
        if (hc == 128 + pix_x[i] && vc == 45 + pix_y[i])
          check_val("pixel", {11'd0, vid.RGB}, {11'd0, pix_c[i]});
      end
      if (do_count && n <= FRAME) begin
        if (!vid.HS)   hs_low++;
        if (!vid.VS)   vs_low++;
        if (vid.BLANK) blank_hi++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val(tag, {6'd0, vid.HS, vid.VS, vid.BLANK, vid.RGB, led[1:0]},
              {6'd0, 1'b1, 1'b1, 1'b0, 24'h000000, 2'b00});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b0;
    sw        = 4'b1010;
    key       = 2'b01;
    hws.rdata = '0;
    hws.ack   = 1'b0;

    #128 rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_reset_outputs("reset");
    end
    check_val("led_sw_key", {29'd0, led[7:2]}, {29'd0, 6'b101001});
    #16 rst = 1'b0;  // release at 256 ns

    run_cycles(FRAME + 1000, 1'b1);
    check_val("hs_low_clks",   35'(hs_low),   35'(48 * 135));
    check_val("vs_low_clks",   35'(vs_low),   35'(3 * 288));
    check_val("blank_hi_clks", 35'(blank_hi), 35'(160 * 90));

    // reset mid-frame: raster must restart from the top-left corner
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("reset_mid");
    end
    rst = 1'b0;
    run_cycles(700, 1'b0);

    check_val("queue_empty", 35'(exp_q.size()), 35'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
